// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the LCD frame writer.
package lcd_pkg;

    localparam int unsigned FRAME_CHARS = 32;
    localparam int unsigned FRAME_BYTES = 34;
    localparam int unsigned INIT_CMDS   = 4;

    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
    localparam logic [7:0] LCD_LINE1     = 8'h80;
    localparam logic [7:0] LCD_LINE2     = 8'hC0;

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, LATCH, XFER} state_e;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_EN, PH_WAIT} phase_e;

    // One bus transfer: register select plus data byte.
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    // Non-printable codes would show as CGRAM glyphs or garbage; blank them.
    function automatic logic [7:0] lcd_sanitise(input logic [7:0] c);
        return ((c < 8'h20) || (c > 8'h7E)) ? 8'h20 : c;
    endfunction

    function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_8B2L;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY_INC;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Single HD44780 bus transfer: setup cycle, EN high pulse, then post-pulse wait.
// done_c fires on the last wait cycle so a new start there chains with no gap.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned EN_HI_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 82000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  lcd_byte_t  payload,
    input  logic       long_wait,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done_c
);

    phase_e             ph_q,   ph_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    lcd_byte_t          byte_q, byte_d;
    logic               long_q, long_d;
    logic               en_q,   en_d;

    always_comb begin
        ph_d   = ph_q;
        cnt_d  = cnt_q;
        byte_d = byte_q;
        long_d = long_q;
        done_c = (ph_q == PH_WAIT) && (cnt_q == '0);
        case (ph_q)
            PH_SETUP: begin
                ph_d  = PH_EN;
                cnt_d = CNT_W'(EN_HI_CYC - 1);
            end
            PH_EN: begin
                if (cnt_q == '0) begin
                    ph_d  = PH_WAIT;
                    cnt_d = long_q ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PH_WAIT: begin
                if (cnt_q == '0) ph_d = PH_IDLE;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
        if (start) begin
            ph_d   = PH_SETUP;
            byte_d = payload;
            long_d = long_wait;
        end
        en_d = (ph_d == PH_EN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q   <= PH_IDLE;
            cnt_q  <= '0;
            byte_q <= '0;
            long_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            cnt_q  <= cnt_d;
            byte_q <= byte_d;
            long_q <= long_d;
            en_q   <= en_d;
        end
    end

    assign lcd_en   = en_q;
    assign lcd_rs   = byte_q.rs;
    assign lcd_data = byte_q.data;

endmodule

// File: rtl/lcd_frame_writer.sv
// Writes 32-char ASCII frames to a 16x2 HD44780 LCD over the 8-bit bus.
// Define LCD_POWERON_INIT_EN to run the power-up init sequence after reset.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned EN_HI_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ASCII [0:FRAME_CHARS-1],
    input  logic       UpdateLCD,
    output logic       LCDBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON
);

    localparam int unsigned MAX_CYC = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned BYTE_W  = 6;
    localparam int unsigned CHAR_W  = $clog2(FRAME_CHARS);
    localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [BYTE_W-1:0] LINE2_BYTE = BYTE_W'(FRAME_CHARS / 2 + 1);
    localparam logic [BYTE_W-1:0] LAST_INIT  = BYTE_W'(INIT_CMDS - 1);

`ifdef LCD_POWERON_INIT_EN
    localparam state_e RST_STATE = PWRUP;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_e RST_STATE = IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_e              state_q,   state_d;
    logic [BYTE_W-1:0]   byte_q,    byte_d;
    logic [CNT_W-1:0]    pwr_q,     pwr_d;
    logic                pending_q, pending_d;
    logic                busy_q,    busy_d;
    logic [7:0]          buf_q [0:FRAME_CHARS-1];
    logic [7:0]          buf_d [0:FRAME_CHARS-1];

    logic                start_c;
    lcd_byte_t           wr_byte_c;
    logic                wr_long_c;
    logic                done_c;
    logic                latch_c;
    logic                seq_end_c;
    logic [BYTE_W-1:0]   nxt_byte_c;
    logic [CHAR_W-1:0]   char_idx_c;

    // Sequencer: picks the next byte on each writer done so transfers run back to back.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        pwr_d      = pwr_q;
        pending_d  = pending_q;
        buf_d      = buf_q;
        start_c    = 1'b0;
        wr_byte_c  = '0;
        latch_c    = 1'b0;
        seq_end_c  = 1'b0;
        nxt_byte_c = byte_q + BYTE_W'(1);
        char_idx_c = (nxt_byte_c < LINE2_BYTE) ? CHAR_W'(nxt_byte_c - BYTE_W'(1))
                                               : CHAR_W'(nxt_byte_c - BYTE_W'(2));
        if ((state_q != IDLE) && UpdateLCD) pending_d = 1'b1;

        case (state_q)
            PWRUP: begin
                if (pwr_q == CNT_W'(PWRUP_CYC - 1)) begin
                    state_d        = INIT;
                    byte_d         = '0;
                    start_c        = 1'b1;
                    wr_byte_c.data = lcd_init_cmd(2'd0);
                end else begin
                    pwr_d = pwr_q + CNT_W'(1);
                end
            end
            INIT: begin
                if (done_c) begin
                    if (byte_q == LAST_INIT) begin
                        seq_end_c = 1'b1;
                    end else begin
                        byte_d         = nxt_byte_c;
                        start_c        = 1'b1;
                        wr_byte_c.data = lcd_init_cmd(2'(nxt_byte_c));
                    end
                end
            end
            IDLE: begin
                if (UpdateLCD || pending_q) begin
                    latch_c   = 1'b1;
                    pending_d = 1'b0;
                end
            end
            LATCH: state_d = XFER;
            XFER: begin
                if (done_c) begin
                    if (byte_q == LAST_BYTE) begin
                        seq_end_c = 1'b1;
                    end else begin
                        byte_d  = nxt_byte_c;
                        start_c = 1'b1;
                        if (nxt_byte_c == LINE2_BYTE) begin
                            wr_byte_c.data = LCD_LINE2;
                        end else begin
                            wr_byte_c.rs   = 1'b1;
                            wr_byte_c.data = lcd_sanitise(buf_q[char_idx_c]);
                        end
                    end
                end
            end
            default: state_d = RST_STATE;
        endcase

        // A strobe landing on the final cycle either starts the next frame or stays pending.
        if (seq_end_c) begin
            pending_d = pending_q & UpdateLCD;
            if (pending_q || UpdateLCD) latch_c = 1'b1;
            else                        state_d = IDLE;
        end

        if (latch_c) begin
            state_d   = LATCH;
            byte_d    = '0;
            buf_d     = ASCII;
            start_c   = 1'b1;
            wr_byte_c = '{rs: 1'b0, data: LCD_LINE1};
        end

        busy_d    = (state_d != IDLE);
        wr_long_c = !wr_byte_c.rs && (wr_byte_c.data == LCD_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_STATE;
            byte_q    <= '0;
            pwr_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= RST_BUSY;
            buf_q     <= '{default: 8'h20};
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            pwr_q     <= pwr_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            buf_q     <= buf_d;
        end
    end

    lcd_byte_writer #(
        .EN_HI_CYC    (EN_HI_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC),
        .CNT_W        (CNT_W)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .start     (start_c),
        .payload   (wr_byte_c),
        .long_wait (wr_long_c),
        .lcd_en    (LCD_EN),
        .lcd_rs    (LCD_RS),
        .lcd_data  (LCD_DATA),
        .done_c    (done_c)
    );

    assign LCDBusy = busy_q;
    assign LCD_RW  = 1'b0;
    assign LCD_ON  = 1'b1;

endmodule
